// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer: one operation per handshake,
// 1-bit-per-cycle shift-add multiply or restoring divide, result held until consumed.
module muldiv_seq #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned WLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFast, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;
  // Multiply: opa = shifting multiplicand, opb = shifting multiplier, acc = product.
  // Divide:   opa = shifting dividend/quotient, opb = divisor, acc = partial remainder.
  logic [XLEN-1:0]   opa_q, opb_q, acc_q;
  logic              is_w_q, is_rem_q, neg_q;

  logic              is_w, is_sgn, is_rem, is_mul, is_rsv;
  logic [XLEN-1:0]   a_ext, b_ext, a_sx, a_mag, b_mag, min_val, fast_res;
  logic              a_neg, b_neg, b_zero, ovf, take_fast;

  logic [XLEN:0]     rem_shift, rem_diff;
  logic [XLEN-1:0]   acc_nx, quo_nx, rem_nx, div_raw, div_sgn, mul_res, div_res;
  logic [CntW-1:0]   iter_last;
  logic              last_iter;

  assign in_ready  = (state_q == StIdle) && reset;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Decode the incoming op and prepare operands, magnitudes and special-case results.
  always_comb begin
    is_w   = (op == 4'd1) || (op >= 4'd6 && op <= 4'd9);
    is_sgn = (op == 4'd2) || (op == 4'd4) || (op == 4'd6) || (op == 4'd8);
    is_rem = (op == 4'd4) || (op == 4'd5) || (op == 4'd8) || (op == 4'd9);
    is_mul = (op <= 4'd1);
    is_rsv = (op >= 4'd10);

    a_sx  = is_w ? {{(XLEN-WLEN){a[WLEN-1]}}, a[WLEN-1:0]} : a;
    a_ext = a;
    b_ext = b;
    if (is_w) begin
      a_ext = is_sgn ? {{(XLEN-WLEN){a[WLEN-1]}}, a[WLEN-1:0]}
                     : {{(XLEN-WLEN){1'b0}}, a[WLEN-1:0]};
      b_ext = is_sgn ? {{(XLEN-WLEN){b[WLEN-1]}}, b[WLEN-1:0]}
                     : {{(XLEN-WLEN){1'b0}}, b[WLEN-1:0]};
    end
    a_neg = is_sgn && a_ext[XLEN-1];
    b_neg = is_sgn && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    min_val = is_w ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                   : {1'b1, {(XLEN-1){1'b0}}};
    b_zero  = (b_ext == '0);
    ovf     = is_sgn && (a_ext == min_val) && (&b_ext);

    take_fast = is_rsv || (!is_mul && (b_zero || ovf));
    fast_res  = '0;
    if (is_rsv)      fast_res = '0;
    else if (b_zero) fast_res = is_rem ? a_sx : '1;
    else if (ovf)    fast_res = is_rem ? '0 : a_ext;
  end

  // One iteration step and the final, sign-corrected result taken on the last step.
  always_comb begin
    acc_nx    = acc_q + (opb_q[0] ? opa_q : '0);
    rem_shift = {acc_q, opa_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    rem_nx    = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
    quo_nx    = {opa_q[XLEN-2:0], ~rem_diff[XLEN]};

    mul_res = is_w_q ? {{(XLEN-WLEN){acc_nx[WLEN-1]}}, acc_nx[WLEN-1:0]} : acc_nx;
    div_raw = is_rem_q ? rem_nx
                       : (is_w_q ? {{(XLEN-WLEN){1'b0}}, quo_nx[WLEN-1:0]} : quo_nx);
    div_sgn = neg_q ? -div_raw : div_raw;
    div_res = is_w_q ? {{(XLEN-WLEN){div_sgn[WLEN-1]}}, div_sgn[WLEN-1:0]} : div_sgn;

    iter_last = is_w_q ? CntW'(WLEN - 1) : CntW'(XLEN - 1);
    last_iter = (cnt_q == iter_last);
  end

  // Sequencer FSM with registered result and out_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            cnt_q    <= '0;
            is_w_q   <= is_w;
            is_rem_q <= is_rem;
            neg_q    <= is_rem ? a_neg : (a_neg ^ b_neg);
            acc_q    <= '0;
            if (take_fast) begin
              result_q <= fast_res;
              state_q  <= StFast;
            end else if (is_mul) begin
              opa_q   <= a;
              opb_q   <= is_w ? {{(XLEN-WLEN){1'b0}}, b[WLEN-1:0]} : b;
              state_q <= StMul;
            end else begin
              // W dividends are pre-shifted so the top bit always feeds the remainder.
              opa_q   <= is_w ? {a_mag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_mag;
              opb_q   <= b_mag;
              state_q <= StDiv;
            end
          end
        end
        StMul: begin
          acc_q <= acc_nx;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            result_q    <= mul_res;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDiv: begin
          acc_q <= rem_nx;
          opa_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            result_q    <= div_res;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StFast: begin
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
